ni_tx_arbiter: RTL and testbench

NI_TX_ARBITER -- requirements
Module: ni_tx_arbiter

---
 rtl/ni_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_ni_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ni_tx_arbiter
//
// Shares one router link between NUM_REQ network-interface output FIFOs.
// A round-robin pointer picks the next non-empty, enabled FIFO. The FSM
// then pops one word from that FIFO, captures it into an output register,
// and holds it toward the router until the router accepts it.
//
// Ports
//   clk         : single clock, all state updates on its rising edge
//   rst_n       : asynchronous active-low reset
//   fifo_empty  : per-requester FIFO empty flag
//   fifo_rd     : per-requester FIFO read strobe (one-hot or zero)
//   fifo_data   : concatenated FIFO outputs, requester i at [i*DATA_W +: DATA_W]
//   req_mask    : per-requester enable, 0 removes a requester from arbitration
//   out_valid   : packet valid toward router
//   out_data    : packet toward router, {addr[63:32], data[31:0]}
//   out_ready   : router accepts the packet
//   grant_id    : requester whose packet is being fetched or held
//   busy        : high whenever the FSM is not idle
//   pkt_count   : packets accepted by the router, wraps at 16 bits
// ---------------------------------------------------------------------------
module ni_tx_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 64,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          fifo_empty,
  output logic [NUM_REQ-1:0]          fifo_rd,
  input  logic [NUM_REQ*DATA_W-1:0]   fifo_data,
  input  logic [NUM_REQ-1:0]          req_mask,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy,
  output logic [15:0]                 pkt_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  logic [1:0]         state;
  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] eligible;
  logic               pick_valid;
  logic [IDW-1:0]     pick_idx;
  logic [DATA_W-1:0]  sel_data;

  // (base + off) modulo NUM_REQ; off never exceeds NUM_REQ-1, so a single
  // conditional subtract is enough and non-power-of-two counts still work.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                               input int             off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[IDW-1:0];
  endfunction

  assign eligible = ~fifo_empty & req_mask;
  assign busy     = (state != ST_IDLE);

  // Walk offsets from the far end toward rr_ptr so the eligible requester
  // closest to rr_ptr (searching upward with wrap) is the one left standing.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[wrap_idx(rr_ptr, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  // Read strobe is decoded from state, so an asynchronous reset (which
  // forces IDLE) drops it in the same instant.
  always_comb begin
    fifo_rd = '0;
    if (state == ST_POP) fifo_rd[grant_id] = 1'b1;
  end

  // Select the granted FIFO's output word.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) sel_data = fifo_data[i*DATA_W +: DATA_W];
    end
  end

  // Main FSM. Eligibility is only looked at in IDLE, so once a grant is
  // registered later changes to req_mask or fifo_empty cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            state    <= ST_POP;
          end
        end
        ST_POP: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          out_data  <= sel_data;
          out_valid <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            pkt_count <= pkt_count + 16'd1;
            rr_ptr    <= wrap_idx(grant_id, 1);
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ni_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ni_tx_arbiter
//
// Drives ni_tx_arbiter from four emulated FIFOs (pop on read strobe, data
// valid the following cycle) and compares every cycle against a
// transaction-level reference model: per-requester queues, a round-robin
// pointer, a phase counter for the fetch pipeline, and a packet counter.
// ---------------------------------------------------------------------------
module tb_ni_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;
  localparam int IDW     = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic [NUM_REQ-1:0]        fifo_empty = '1;
  logic [NUM_REQ-1:0]        fifo_rd;
  logic [NUM_REQ*DATA_W-1:0] fifo_data;
  logic [NUM_REQ-1:0]        req_mask = '1;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_ready = 1'b0;
  logic [IDW-1:0]            grant_id;
  logic                      busy;
  logic [15:0]               pkt_count;

  // FIFO emulation
  logic [DATA_W-1:0] data_reg [NUM_REQ] = '{default: '0};
  logic [DATA_W-1:0] fq [NUM_REQ][$];
  logic [NUM_REQ-1:0] rd_seen = '0;

  // reference model
  logic [DATA_W-1:0] mq [NUM_REQ][$];
  int                m_phase = 0;
  int                m_grant = 0;
  int                m_rr    = 0;
  int                m_count = 0;
  logic [DATA_W-1:0] m_popped = '0;
  logic [DATA_W-1:0] m_data   = '0;
  int                grant_log[$];

  // stimulus configuration
  bit                cfg_ready_rand = 1'b0;
  logic              cfg_ready      = 1'b1;
  int                cfg_push_pct   = 0;
  logic [NUM_REQ-1:0] cfg_push_sel  = '0;
  bit                cfg_mask_rand  = 1'b0;
  logic [NUM_REQ-1:0] cfg_mask      = '1;
  logic [31:0]       seq_no         = 32'd1;

  int num_checks = 0;
  int num_fail   = 0;

  always #5 clk = ~clk;

  ni_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .req_mask   (req_mask),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo_out
    assign fifo_data[g*DATA_W +: DATA_W] = data_reg[g];
  end

  // Emulated FIFOs pop on the edge that ends the read-strobe cycle.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_seen[i]) begin
        if (fq[i].size() > 0) data_reg[i] <= fq[i].pop_front();
        else                  data_reg[i] <= '0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushItem(input int idx, input logic [DATA_W-1:0] v);
    fq[idx].push_back(v);
    mq[idx].push_back(v);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cfg_push_sel[i] && ($urandom_range(99) < 32'(cfg_push_pct)) && fq[i].size() < 6) begin
        pushItem(i, {seq_no, 32'($urandom())});
        seq_no = seq_no + 32'd1;
      end
      fifo_empty[i] = (fq[i].size() == 0);
    end
    out_ready = cfg_ready_rand ? 1'($urandom_range(1)) : cfg_ready;
    if (cfg_mask_rand) begin
      if ($urandom_range(9) == 0) req_mask = 4'($urandom_range(15));
    end else begin
      req_mask = cfg_mask;
    end
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic modelStep();
    logic [NUM_REQ-1:0] elig;
    bit found;
    int idx;
    case (m_phase)
      0: begin
        elig  = ~fifo_empty & req_mask;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_rr + k) % NUM_REQ;
          if (!found && elig[idx]) begin
            found   = 1'b1;
            m_grant = idx;
            m_phase = 1;
          end
        end
      end
      1: begin
        m_popped = (mq[m_grant].size() > 0) ? mq[m_grant].pop_front() : '0;
        m_phase  = 2;
      end
      2: begin
        m_data  = m_popped;
        m_phase = 3;
      end
      default: begin
        if (out_ready) begin
          m_count = (m_count + 1) % 65536;
          m_rr    = (m_grant + 1) % NUM_REQ;
          m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic runCycle();
    logic [NUM_REQ-1:0] exp_rd;
    @(negedge clk);
    exp_rd = (m_phase == 1) ? (4'b0001 << m_grant) : 4'b0000;
    checkOutput("fifo_rd", 64'(fifo_rd), 64'(exp_rd));
    checkOutput("out_valid", 64'(out_valid), 64'(m_phase == 3));
    checkOutput("busy", 64'(busy), 64'(m_phase != 0));
    checkOutput("pkt_count", 64'(pkt_count), 64'(m_count));
    if (m_phase != 0) checkOutput("grant_id", 64'(grant_id), 64'(m_grant));
    if (m_phase == 3) checkOutput("out_data", out_data, m_data);
    for (int i = 0; i < NUM_REQ; i++) if (fifo_rd[i] === 1'b1) grant_log.push_back(i);
    rd_seen = fifo_rd;
    applyStimulus();
    if (rst_n) modelStep();
  endtask

  // Reset lands mid-cycle so the asynchronous clear is observed directly.
  task automatic doReset(input int hold);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
    checkOutput("rst_pkt_count", 64'(pkt_count), 64'd0);
    m_phase = 0;
    m_rr    = 0;
    m_grant = 0;
    m_count = 0;
    rd_seen = '0;
    repeat (hold) runCycle();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic waitForSend();
    int budget;
    budget = 0;
    while (m_phase != 3 && budget < 60) begin
      runCycle();
      budget++;
    end
    checkOutput("wait_send_reached", 64'(m_phase == 3), 64'd1);
  endtask

  task automatic fillAll(input int n);
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < n; j++) begin
        pushItem(i, {seq_no, 32'($urandom())});
        seq_no = seq_no + 32'd1;
      end
    end
  endtask

  task automatic drainQueues();
    for (int i = 0; i < NUM_REQ; i++) begin
      fq[i].delete();
      mq[i].delete();
    end
  endtask

  initial begin
    int exp_cnt;
    // power-up reset, nothing queued, router toggling ready
    doReset(2);
    cfg_ready_rand = 1'b1;
    repeat (20) runCycle();

    // only FIFO 2 holds a packet
    cfg_ready_rand = 1'b0;
    cfg_ready      = 1'b1;
    grant_log.delete();
    pushItem(2, 64'h00001000_DEADBEEF);
    repeat (8) runCycle();
    checkOutput("single_pkt_count", 64'(pkt_count), 64'd1);
    checkOutput("single_grant_cnt", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() > 0) checkOutput("single_grant_idx", 64'(grant_log[0]), 64'd2);
    checkOutput("single_out_data", out_data, 64'h00001000_DEADBEEF);

    // all four busy: round robin from index 0
    doReset(2);
    drainQueues();
    grant_log.delete();
    fillAll(6);
    repeat (21) runCycle();
    checkOutput("rr_grant_cnt_ge5", 64'(grant_log.size() >= 5), 64'd1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      checkOutput("rr_grant_seq", 64'(grant_log[k]), 64'(k % NUM_REQ));

    // router stalls for 10 cycles while a packet is held
    cfg_ready = 1'b0;
    waitForSend();
    grant_log.delete();
    repeat (10) runCycle();
    checkOutput("stall_no_rd", 64'(grant_log.size()), 64'd0);
    exp_cnt   = m_count + 1;
    cfg_ready = 1'b1;
    repeat (2) runCycle();
    checkOutput("stall_release_cnt", 64'(pkt_count), 64'(exp_cnt));

    // mask 1010: only 1 and 3 alternate
    doReset(2);
    drainQueues();
    grant_log.delete();
    cfg_mask = 4'b1010;
    fillAll(6);
    repeat (24) runCycle();
    checkOutput("mask_grant_cnt_ge4", 64'(grant_log.size() >= 4), 64'd1);
    for (int k = 0; k < grant_log.size(); k++)
      checkOutput("mask_grant_seq", 64'(grant_log[k]), 64'((k % 2 == 0) ? 1 : 3));

    // reset while a packet is held in SEND
    cfg_mask  = 4'b1111;
    cfg_ready = 1'b0;
    waitForSend();
    doReset(3);
    grant_log.delete();
    cfg_ready = 1'b1;
    fillAll(1);
    repeat (6) runCycle();
    checkOutput("post_rst_grant_cnt", 64'(grant_log.size() >= 1), 64'd1);
    if (grant_log.size() > 0) checkOutput("post_rst_grant0", 64'(grant_log[0]), 64'd0);

    // random traffic, random ready, random mask, occasional resets
    cfg_ready_rand = 1'b1;
    cfg_mask_rand  = 1'b1;
    cfg_push_sel   = 4'b1111;
    cfg_push_pct   = 35;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(599) == 0) doReset(1 + int'($urandom_range(2)));
      else runCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
